// File: rtl/bias_bram_arbiter.sv
// bias_bram_arbiter: two-port burst-read arbiter and address sequencer for the bias BRAM.
// Define BIAS_ARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module bias_bram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_base,
  input  logic [LEN_W-1:0]  r0_len,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_data,
  output logic              r0_vld,
  output logic              r0_last,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_base,
  input  logic [LEN_W-1:0]  r1_len,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_data,
  output logic              r1_vld,
  output logic              r1_last,
  output logic              bias_bram_en,
  output logic [ADDR_W-1:0] bias_bram_addr,
  input  logic [DATA_W-1:0] bias_bram_dout,
  input  logic              bias_bram_rd_vld,
  output logic              busy
);
  typedef enum logic {IDLE, READ} state_t;
  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic              owner, pipe_valid, pipe_owner, pipe_last, win;
  logic [ADDR_W-1:0] win_base;
  logic [LEN_W-1:0]  win_len;
`ifdef BIAS_ARB_RR_EN
  logic ptr;
  assign win = r1_req & (~r0_req | ptr);
`else
  assign win = ~r0_req;
`endif
  assign win_base = win ? r1_base : r0_base;
  assign win_len  = win ? r1_len : r0_len;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      owner          <= 1'b0;
      r0_ack         <= 1'b0;
      r1_ack         <= 1'b0;
      bias_bram_en   <= 1'b0;
      bias_bram_addr <= '0;
      pipe_valid     <= 1'b0;
      pipe_owner     <= 1'b0;
      pipe_last      <= 1'b0;
`ifdef BIAS_ARB_RR_EN
      ptr            <= 1'b0;
`endif
    end else begin
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      pipe_valid <= bias_bram_en;
      pipe_owner <= owner;
      pipe_last  <= bias_bram_en & (cnt == LEN_W'(1));
      if (state == IDLE) begin
        if (r0_req | r1_req) begin
          r0_ack <= ~win;
          r1_ack <= win;
`ifdef BIAS_ARB_RR_EN
          ptr    <= ~win;
`endif
          // zero-length bursts are acknowledged without touching the BRAM
          if (win_len != '0) begin
            state          <= READ;
            bias_bram_en   <= 1'b1;
            bias_bram_addr <= win_base;
            cnt            <= win_len;
            owner          <= win;
          end
        end
      end else begin
        bias_bram_addr <= bias_bram_addr + 1'b1;
        cnt            <= cnt - 1'b1;
        if (cnt == LEN_W'(1)) begin
          state        <= IDLE;
          bias_bram_en <= 1'b0;
        end
      end
    end
  end
  assign r0_data = bias_bram_dout;
  assign r1_data = bias_bram_dout;
  assign r0_vld  = bias_bram_rd_vld & pipe_valid & ~pipe_owner;
  assign r1_vld  = bias_bram_rd_vld & pipe_valid & pipe_owner;
  assign r0_last = r0_vld & pipe_last;
  assign r1_last = r1_vld & pipe_last;
  assign busy    = (state == READ) | pipe_valid;
endmodule

// File: tb/tb_bias_bram_arbiter.sv
// tb_bias_bram_arbiter: directed checks of grant timing, burst addressing, routing and reset.
module tb_bias_bram_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        r0_req = 0, r1_req = 0;
  logic [6:0]  r0_base = 0, r1_base = 0;
  logic [7:0]  r0_len = 0, r1_len = 0;
  logic        r0_ack, r1_ack, r0_vld, r1_vld, r0_last, r1_last, en, busy;
  logic [31:0] r0_data, r1_data;
  logic [6:0]  addr;
  logic [31:0] dout = 0;
  logic        rd_vld = 0;
  int          cyc = 0, vecs = 0, errs = 0;
  typedef struct {int c; logic [32:0] v;} ev_t;
  ev_t en_q[$], v0_q[$], v1_q[$], a0_q[$], a1_q[$];

  bias_bram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_base(r0_base), .r0_len(r0_len), .r0_ack(r0_ack),
    .r0_data(r0_data), .r0_vld(r0_vld), .r0_last(r0_last),
    .r1_req(r1_req), .r1_base(r1_base), .r1_len(r1_len), .r1_ack(r1_ack),
    .r1_data(r1_data), .r1_vld(r1_vld), .r1_last(r1_last),
    .bias_bram_en(en), .bias_bram_addr(addr), .bias_bram_dout(dout),
    .bias_bram_rd_vld(rd_vld), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // BRAM model: mem[a] = a + 100, one-cycle read latency
  always @(posedge clk) begin
    rd_vld <= en;
    dout   <= 32'(addr) + 32'd100;
  end
  always @(negedge clk) begin
    if (en) en_q.push_back('{cyc, 33'(addr)});
    if (r0_vld) v0_q.push_back('{cyc, {r0_last, r0_data}});
    if (r1_vld) v1_q.push_back('{cyc, {r1_last, r1_data}});
    if (r0_ack) a0_q.push_back('{cyc, 33'd0});
    if (r1_ack) a1_q.push_back('{cyc, 33'd0});
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic clr();
    en_q.delete(); v0_q.delete(); v1_q.delete(); a0_q.delete(); a1_q.delete();
  endtask
  task automatic issue(input bit p, input logic [6:0] b, input logic [7:0] l, output int rc);
    bit got = 0;
    if (p) begin r1_req = 1; r1_base = b; r1_len = l; end
    else begin r0_req = 1; r0_base = b; r0_len = l; end
    rc = cyc;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = p ? r1_ack : r0_ack;
    end
    if (p) r1_req = 0; else r0_req = 0;
    chk("ack_seen", got, 1);
  endtask

  initial begin
    int rc, st;
    int order[$];
`ifdef BIAS_ARB_RR_EN
    int exp_ord[3] = '{0, 1, 0};
    int exp_adr[6] = '{0, 1, 10, 11, 0, 1};
`else
    int exp_ord[3] = '{0, 0, 1};
    int exp_adr[6] = '{0, 1, 0, 1, 10, 11};
`endif
    idle(2);
    chk("rst_en", en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ack", r0_ack | r1_ack, 0);
    chk("rst_vld", r0_vld | r1_vld, 0);
    chk("rst_last", r0_last | r1_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    idle(2);
    clr();
    // r0 base 5 len 3
    issue(0, 7'd5, 8'd3, rc);
    idle(6);
    chk("t1_acks", a0_q.size(), 1);
    chk("t1_ack_cyc", a0_q[0].c, rc + 1);
    chk("t1_en_n", en_q.size(), 3);
    chk("t1_v0_n", v0_q.size(), 3);
    chk("t1_v1_n", v1_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", en_q[i].v, 5 + i);
      chk("t1_en_cyc", en_q[i].c, rc + 1 + i);
      chk("t1_data", v0_q[i].v[31:0], 105 + i);
      chk("t1_last", v0_q[i].v[32], i == 2);
      chk("t1_vld_cyc", v0_q[i].c, rc + 2 + i);
    end
    clr();
    // r1 base 126 len 4, address wraps
    issue(1, 7'd126, 8'd4, rc);
    idle(7);
    chk("t2_en_n", en_q.size(), 4);
    chk("t2_v1_n", v1_q.size(), 4);
    chk("t2_v0_n", v0_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", en_q[i].v, (126 + i) % 128);
      chk("t2_data", v1_q[i].v[31:0], (126 + i) % 128 + 100);
      chk("t2_last", v1_q[i].v[32], i == 3);
    end
    clr();
    // simultaneous r0/r1, r0 re-raised after its ack
    r0_req = 1; r0_base = 0; r0_len = 2;
    r1_req = 1; r1_base = 10; r1_len = 2;
    st = 0;
    for (int k = 0; k < 40 && order.size() < 3; k++) begin
      tick();
      if (st == 1) begin r0_req = 1; st = 2; end
      if (r0_ack) begin order.push_back(0); r0_req = 0; if (st == 0) st = 1; end
      if (r1_ack) begin order.push_back(1); r1_req = 0; end
    end
    r0_req = 0; r1_req = 0;
    idle(6);
    chk("rr_grants", order.size(), 3);
    for (int i = 0; i < 3; i++) chk("rr_order", order[i], exp_ord[i]);
    chk("rr_en_n", en_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_addr", en_q[i].v, exp_adr[i]);
    chk("rr_v0_n", v0_q.size(), 4);
    chk("rr_v1_n", v1_q.size(), 2);
    clr();
    // zero-length burst
    issue(0, 7'd50, 8'd0, rc);
    idle(4);
    chk("z_acks", a0_q.size(), 1);
    chk("z_en_n", en_q.size(), 0);
    chk("z_v0_n", v0_q.size(), 0);
    chk("z_busy", busy, 0);
    clr();
    // back-to-back 2-word bursts
    r0_req = 1; r0_base = 20; r0_len = 2;
    rc = cyc;
    tick();
    chk("bb_ack0", r0_ack, 1);
    r0_req = 0;
    r1_req = 1; r1_base = 30; r1_len = 2;
    st = 0;
    for (int k = 0; k < 20 && st == 0; k++) begin
      tick();
      st = r1_ack;
    end
    r1_req = 0;
    chk("bb_ack1_seen", st, 1);
    idle(5);
    chk("bb_en_n", en_q.size(), 4);
    chk("bb_en0_cyc", en_q[0].c, rc + 1);
    chk("bb_en2_cyc", en_q[2].c, rc + 4);
    chk("bb_gap", en_q[2].c - en_q[1].c, 2);
    chk("bb_addr2", en_q[2].v, 30);
    chk("bb_v0_n", v0_q.size(), 2);
    chk("bb_last_cyc", v0_q[1].c, rc + 3);
    chk("bb_last_flag", v0_q[1].v[32], 1);
    chk("bb_last_data", v0_q[1].v[31:0], 121);
    chk("bb_v1_n", v1_q.size(), 2);
    clr();
    // asynchronous reset on the 2nd enable of a len=4 burst
    issue(0, 7'd40, 8'd4, rc);
    tick();
    chk("ar_en_pre", en, 1);
    chk("ar_vld_pre", r0_vld, 1);
    chk("ar_data_pre", r0_data, 140);
    rst_n = 0;
    #1;
    chk("ar_en", en, 0);
    chk("ar_vld", r0_vld, 0);
    chk("ar_busy", busy, 0);
    chk("ar_last", r0_last, 0);
    idle(2);
    rst_n = 1;
    clr();
    idle(6);
    chk("ar_en_after", en_q.size(), 0);
    chk("ar_vld_after", v0_q.size() + v1_q.size(), 0);
    chk("ar_ack_after", a0_q.size() + a1_q.size(), 0);
    chk("ar_busy_after", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
